pc_unit: RTL and testbench
==========================

PC_UNIT -- requirements
Module: pc_unit

Interface
REQ-001 SHALL have parameter XLEN, default 32, meaning PC/address width; legal values are 32 or 64.
REQ-002 SHALL have parameter RESET_VECTOR, default 0, meaning the PC value after reset.
REQ-003 SHALL have parameter EXC_VECTOR, default 32'h80, meaning the exception handler entry address.
REQ-004 SHALL have parameter RAS_DEPTH, default 4, meaning return-address-stack entries; legal values are powers of 2 from 2 to 16.
REQ-005 SHALL have ports, each as name  direction  width  meaning:
 clk  in  1  clock
 reset  in  1  synchronous, active-high reset
 stall  in  1  hold the PC
 branch_taken  in  1  take the branch
 branch_offset  in  XLEN  pre-shifted byte offset
 jump  in  1  absolute jump
 jump_link  in  1  with jump: push pc_plus_4 onto the RAS
 jr  in  1  register jump
 jr_addr  in  XLEN  register target
 ret  in  1  with jr: pop the RAS as the target
 exc  in  1  exception request
 eret  in  1  exception return
 jump_target  in  26  instruction index
 pc  out  XLEN  current PC
 pc_plus_4  out  XLEN  pc+4, combinational
 epc  out  XLEN  saved exception PC
 pc_valid  out  1  PC is fetchable
 in_handler  out  1  state is HANDLER
 halted  out  1  state is HALT
 ras_count  out  $clog2(RAS_DEPTH)+1  occupied RAS entries
 ras_overflow  out  1  one-cycle pulse
 ras_underflow  out  1  one-cycle pulse
 addr_err  out  1  one-cycle pulse on a misaligned jr target

Function
REQ-006 SHALL implement an FSM with states BOOT, RUN, HANDLER and HALT; reset enters BOOT.
REQ-007 BOOT SHALL last exactly one cycle with pc_valid=0 and pc=RESET_VECTOR, then go to RUN regardless of inputs.
REQ-008 In RUN or HANDLER, pc_valid SHALL be 1; in HALT, pc SHALL be frozen, pc_valid=0 and halted=1 until reset.
REQ-009 next-PC selection SHALL use strict priority: exc > addr_err > eret > jr > jump > branch_taken > pc+4; only the winning event updates state or the RAS.
REQ-010 exc in RUN SHALL load epc<=pc, set pc<=EXC_VECTOR and enter HANDLER; exc in HANDLER SHALL enter HALT (double fault) with epc unchanged.
REQ-011 When jr is the winner and its target has bits [1:0]!=0, the block SHALL pulse addr_err and act as exc (same state and epc rules).
REQ-012 eret in HANDLER SHALL set pc<=epc and enter RUN; eret in RUN SHALL be ignored and the PC advances normally.
REQ-013 The jump address SHALL be {pc_plus_4[XLEN-1:28], jump_target, 2'b00}.
REQ-014 The branch target SHALL be pc_plus_4+branch_offset, modulo 2^XLEN, with no overflow flag; pc+4 SHALL also wrap.
REQ-015 jump with jump_link SHALL push pc_plus_4; when the RAS is full the push SHALL overwrite the oldest entry, leave ras_count at RAS_DEPTH and pulse ras_overflow.
REQ-016 jr with ret and a non-empty RAS SHALL target the top entry and pop it; with an empty RAS it SHALL target jr_addr and pulse ras_underflow.
REQ-017 jump_link without jump, and ret without jr, SHALL be ignored.
REQ-018 stall=1 SHALL hold pc and the RAS and discard all lower-priority events; exc SHALL still be taken during stall.
REQ-019 State changes, pc, epc and the RAS SHALL update only on the rising edge of clk; the resulting pc SHALL be visible one cycle after the event.

Reset
REQ-020 reset SHALL win over all inputs, including during stall or in HALT.
REQ-021 After reset: pc=RESET_VECTOR, epc=0, ras_count=0, all pulses 0, in_handler=0, halted=0, pc_valid=0.

Structure
REQ-022 The FSM state enum and the default vectors SHALL live in the shared package cpu_pkg.
REQ-023 The RAS SHALL be a separate sub-module, pc_ras, parametrised by XLEN and RAS_DEPTH, providing push, pop, top, count and pulse outputs.
REQ-024 pc+4 and the branch adder SHALL be parametrised to XLEN with no hard-coded 32.

Verification
REQ-025 Release reset -> one cycle with pc=0 and pc_valid=0, then pc steps 0,4,8,C.
REQ-026 At pc=0x10, branch_taken with offset 0x20 -> pc=0x34 next cycle; at pc=0x100, jump with target 0x40 -> pc=0x100.
REQ-027 Five nested jump_link calls with RAS_DEPTH=4 -> overflow pulse on the 5th call; four ret pops return the four newest links in LIFO order; the 5th ret gives underflow and takes jr_addr.
REQ-028 exc at pc=0x200 -> pc=0x80 and epc=0x200; eret -> pc=0x200; a second exc while in HANDLER -> halted=1 and pc frozen.
REQ-029 jr with jr_addr=0x102 -> addr_err pulse, pc=EXC_VECTOR; stall held 3 cycles -> pc constant; exc during stall is taken.

Source files
------------

// File: rtl/cpu_pkg.sv
// cpu_pkg -- definitions shared by the program-counter blocks.
//
// Contents:
//   pc_state_e            lifecycle states of the PC sequencer
//   DEFAULT_RESET_VECTOR  PC after reset (64 bits wide, truncated to XLEN by users)
//   DEFAULT_EXC_VECTOR    exception handler entry (64 bits wide, truncated to XLEN)
package cpu_pkg;

   // BOOT is the single idle cycle after reset.
   // HALT is only left through reset.
   typedef enum logic [1:0] {
      BOOT    = 2'd0,
      RUN     = 2'd1,
      HANDLER = 2'd2,
      HALT    = 2'd3
   } pc_state_e;

   localparam logic [63:0] DEFAULT_RESET_VECTOR = 64'h0;
   localparam logic [63:0] DEFAULT_EXC_VECTOR   = 64'h80;

endpackage

// File: rtl/pc_ras.sv
// pc_ras -- circular return-address stack.
//
// Parameters: XLEN (entry width), RAS_DEPTH (entries, power of two).
// Ports:
//   clk, reset        clock, synchronous active-high reset
//   push, push_data   push an entry; when full, the oldest entry is overwritten
//   pop               remove the top entry; popping an empty stack flags underflow
//   top               newest entry (undefined while count is 0)
//   count             occupied entries, 0..RAS_DEPTH
//   overflow          one-cycle pulse after a push into a full stack
//   underflow         one-cycle pulse after a pop of an empty stack
module pc_ras #(
   parameter int XLEN      = 32,
   parameter int RAS_DEPTH = 4
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic                           push,
   input  logic                           pop,
   input  logic [XLEN-1:0]                push_data,
   output logic [XLEN-1:0]                top,
   output logic [$clog2(RAS_DEPTH):0]     count,
   output logic                           overflow,
   output logic                           underflow
);

   localparam int PW = $clog2(RAS_DEPTH);
   localparam int CW = PW + 1;

   logic [XLEN-1:0] stack [RAS_DEPTH];
   logic [PW-1:0]   ptr;

   // ptr is the next free slot. Once the stack is full it also points at the
   // oldest entry, so a push there overwrites it and the ring keeps the newest.
   assign top = stack[ptr - PW'(1)];

   // Entry storage carries no reset; count decides which slots are meaningful.
   always_ff @(posedge clk) begin
      if (!reset && push) begin
         stack[ptr] <= push_data;
      end
   end

   // Pointer, occupancy and the status pulses.
   always_ff @(posedge clk) begin
      if (reset) begin
         ptr       <= '0;
         count     <= '0;
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else begin
         overflow  <= 1'b0;
         underflow <= 1'b0;
         if (push) begin
            ptr <= ptr + PW'(1);
            if (count == CW'(RAS_DEPTH)) begin
               overflow <= 1'b1;
            end else begin
               count <= count + CW'(1);
            end
         end else if (pop) begin
            if (count == '0) begin
               underflow <= 1'b1;
            end else begin
               ptr   <= ptr - PW'(1);
               count <= count - CW'(1);
            end
         end
      end
   end

endmodule

// File: rtl/pc_unit.sv
// pc_unit -- program counter sequencer with a return-address stack,
// exception entry/return and double-fault halt.
//
// Parameters: XLEN (32 or 64), RESET_VECTOR, EXC_VECTOR, RAS_DEPTH.
// Ports:
//   clk, reset                  clock, synchronous active-high reset
//   stall                       hold the PC (exceptions are still taken)
//   branch_taken/branch_offset  relative branch from pc+4
//   jump/jump_target/jump_link  region jump, optionally pushing pc+4
//   jr/jr_addr/ret              register jump, optionally popping the RAS
//   exc, eret                   exception request / return
//   pc, pc_plus_4, epc          current PC, its successor, saved exception PC
//   pc_valid/in_handler/halted  state decode
//   ras_count                   occupied RAS entries
//   ras_overflow/ras_underflow  one-cycle RAS pulses
//   addr_err                    one-cycle pulse on a misaligned register jump
module pc_unit
   import cpu_pkg::*;
#(
   parameter int          XLEN         = 32,
   parameter logic [63:0] RESET_VECTOR = DEFAULT_RESET_VECTOR,
   parameter logic [63:0] EXC_VECTOR   = DEFAULT_EXC_VECTOR,
   parameter int          RAS_DEPTH    = 4
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        stall,
   input  logic                        branch_taken,
   input  logic [XLEN-1:0]             branch_offset,
   input  logic                        jump,
   input  logic                        jump_link,
   input  logic                        jr,
   input  logic [XLEN-1:0]             jr_addr,
   input  logic                        ret,
   input  logic                        exc,
   input  logic                        eret,
   input  logic [25:0]                 jump_target,
   output logic [XLEN-1:0]             pc,
   output logic [XLEN-1:0]             pc_plus_4,
   output logic [XLEN-1:0]             epc,
   output logic                        pc_valid,
   output logic                        in_handler,
   output logic                        halted,
   output logic [$clog2(RAS_DEPTH):0]  ras_count,
   output logic                        ras_overflow,
   output logic                        ras_underflow,
   output logic                        addr_err
);

   pc_state_e       state;
   logic [XLEN-1:0] jump_addr;
   logic [XLEN-1:0] branch_addr;
   logic [XLEN-1:0] jr_target;
   logic [XLEN-1:0] ras_top;
   logic            active;
   logic            fault;
   logic            open_slot;
   logic            misaligned_win;
   logic            eret_win;
   logic            jr_win;
   logic            jump_win;
   logic            branch_win;
   logic            ras_push;
   logic            ras_pop;

   // Candidate targets; all adders wrap at 2^XLEN.
   assign pc_plus_4   = pc + XLEN'(4);
   assign branch_addr = pc_plus_4 + branch_offset;
   assign jump_addr   = {pc_plus_4[XLEN-1:28], jump_target, 2'b00};

   // A return with an empty stack falls back to the register target.
   assign jr_target = (ret && ras_count != '0) ? ras_top : jr_addr;

   // Priority chain. open_slot means nothing above addr_err (exception,
   // stall) claimed the cycle; each later winner excludes the earlier ones.
   // eret outside HANDLER is treated as absent so lower events still apply.
   assign active         = (state == RUN) || (state == HANDLER);
   assign open_slot      = active && !exc && !stall;
   assign misaligned_win = open_slot && jr && (jr_target[1:0] != 2'b00);
   assign fault          = (active && exc) || misaligned_win;
   assign eret_win       = open_slot && !misaligned_win && eret && (state == HANDLER);
   assign jr_win         = open_slot && !misaligned_win && !eret_win && jr;
   assign jump_win       = open_slot && !eret_win && !jr && jump;
   assign branch_win     = open_slot && !eret_win && !jr && !jump && branch_taken;

   assign ras_push = jump_win && jump_link;
   assign ras_pop  = jr_win && ret;

   pc_ras #(
      .XLEN      (XLEN),
      .RAS_DEPTH (RAS_DEPTH)
   ) u_ras (
      .clk       (clk),
      .reset     (reset),
      .push      (ras_push),
      .pop       (ras_pop),
      .push_data (pc_plus_4),
      .top       (ras_top),
      .count     (ras_count),
      .overflow  (ras_overflow),
      .underflow (ras_underflow)
   );

   // Lifecycle FSM and PC/EPC registers. A fault in RUN enters the handler;
   // a fault while already in HANDLER is a double fault and halts with pc
   // and epc left untouched.
   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= BOOT;
         pc       <= RESET_VECTOR[XLEN-1:0];
         epc      <= '0;
         addr_err <= 1'b0;
      end else begin
         addr_err <= 1'b0;
         case (state)
            BOOT: begin
               state <= RUN;
            end
            RUN, HANDLER: begin
               if (fault) begin
                  addr_err <= misaligned_win;
                  if (state == RUN) begin
                     epc   <= pc;
                     pc    <= EXC_VECTOR[XLEN-1:0];
                     state <= HANDLER;
                  end else begin
                     state <= HALT;
                  end
               end else if (stall) begin
                  pc <= pc;
               end else if (eret_win) begin
                  pc    <= epc;
                  state <= RUN;
               end else if (jr_win) begin
                  pc <= jr_target;
               end else if (jump_win) begin
                  pc <= jump_addr;
               end else if (branch_win) begin
                  pc <= branch_addr;
               end else begin
                  pc <= pc_plus_4;
               end
            end
            default: begin
               state <= HALT;
            end
         endcase
      end
   end

   assign pc_valid   = active;
   assign in_handler = (state == HANDLER);
   assign halted     = (state == HALT);

endmodule

// File: tb/tb_pc_unit.sv
// tb_pc_unit -- directed and randomized checks of pc_unit against a
// behavioural model (plain arithmetic plus a queue for the return stack).
module tb_pc_unit;

   logic        clk = 1'b0;
   logic        reset;
   logic        stall;
   logic        branch_taken;
   logic [31:0] branch_offset;
   logic        jump;
   logic        jump_link;
   logic        jr;
   logic [31:0] jr_addr;
   logic        ret;
   logic        exc;
   logic        eret;
   logic [25:0] jump_target;
   logic [31:0] pc;
   logic [31:0] pc_plus_4;
   logic [31:0] epc;
   logic        pc_valid;
   logic        in_handler;
   logic        halted;
   logic [2:0]  ras_count;
   logic        ras_overflow;
   logic        ras_underflow;
   logic        addr_err;

   int n_compared   = 0;
   int n_mismatched = 0;

   // Model state.
   logic [31:0] m_pc;
   logic [31:0] m_epc;
   bit          m_boot;
   bit          m_handler;
   bit          m_halted;
   bit          m_ovf;
   bit          m_unf;
   bit          m_aerr;
   logic [31:0] m_ras[$];
   logic [31:0] saved_pc;

   pc_unit dut (
      .clk           (clk),
      .reset         (reset),
      .stall         (stall),
      .branch_taken  (branch_taken),
      .branch_offset (branch_offset),
      .jump          (jump),
      .jump_link     (jump_link),
      .jr            (jr),
      .jr_addr       (jr_addr),
      .ret           (ret),
      .exc           (exc),
      .eret          (eret),
      .jump_target   (jump_target),
      .pc            (pc),
      .pc_plus_4     (pc_plus_4),
      .epc           (epc),
      .pc_valid      (pc_valid),
      .in_handler    (in_handler),
      .halted        (halted),
      .ras_count     (ras_count),
      .ras_overflow  (ras_overflow),
      .ras_underflow (ras_underflow),
      .addr_err      (addr_err)
   );

   always #5 clk = ~clk;

   task automatic clearInputs();
      reset = 0; stall = 0; branch_taken = 0; branch_offset = 0;
      jump = 0; jump_link = 0; jr = 0; jr_addr = 0; ret = 0;
      exc = 0; eret = 0; jump_target = 0;
   endtask

   task automatic takeFault();
      if (m_handler) begin
         m_handler = 0;
         m_halted  = 1;
      end else begin
         m_epc     = m_pc;
         m_pc      = 32'h80;
         m_handler = 1;
      end
   endtask

   // Reference behaviour for one clock edge, computed from the current inputs.
   task automatic modelStep();
      logic [31:0] p4;
      logic [31:0] tgt;
      m_ovf = 0; m_unf = 0; m_aerr = 0;
      p4 = m_pc + 32'd4;
      if (reset) begin
         m_pc = 0; m_epc = 0; m_ras.delete();
         m_boot = 1; m_handler = 0; m_halted = 0;
      end else if (m_boot) begin
         m_boot = 0;
      end else if (m_halted) begin
         m_halted = 1;
      end else if (exc) begin
         takeFault();
      end else if (!stall) begin
         tgt = (jr && ret && m_ras.size() > 0) ? m_ras[$] : jr_addr;
         if (jr && (tgt % 4) != 0) begin
            m_aerr = 1;
            takeFault();
         end else if (eret && m_handler) begin
            m_pc = m_epc;
            m_handler = 0;
         end else if (jr) begin
            if (ret) begin
               if (m_ras.size() > 0) void'(m_ras.pop_back());
               else m_unf = 1;
            end
            m_pc = tgt;
         end else if (jump) begin
            if (jump_link) begin
               if (m_ras.size() == 4) begin
                  void'(m_ras.pop_front());
                  m_ovf = 1;
               end
               m_ras.push_back(p4);
            end
            m_pc = (p4 & 32'hF000_0000) | (32'(jump_target) * 32'd4);
         end else if (branch_taken) begin
            m_pc = p4 + branch_offset;
         end else begin
            m_pc = p4;
         end
      end
   endtask

   task automatic checkField(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_compared++;
      assert (obs === exp) else begin
         n_mismatched++;
         $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic checkOutput(input string tag);
      checkField({tag, ".pc"},            64'(pc),            64'(m_pc));
      checkField({tag, ".pc_plus_4"},     64'(pc_plus_4),     64'(m_pc + 32'd4));
      checkField({tag, ".epc"},           64'(epc),           64'(m_epc));
      checkField({tag, ".pc_valid"},      64'(pc_valid),      64'(!m_boot && !m_halted));
      checkField({tag, ".in_handler"},    64'(in_handler),    64'(m_handler));
      checkField({tag, ".halted"},        64'(halted),        64'(m_halted));
      checkField({tag, ".ras_count"},     64'(ras_count),     64'(m_ras.size()));
      checkField({tag, ".ras_overflow"},  64'(ras_overflow),  64'(m_ovf));
      checkField({tag, ".ras_underflow"}, 64'(ras_underflow), 64'(m_unf));
      checkField({tag, ".addr_err"},      64'(addr_err),      64'(m_aerr));
   endtask

   // Advance one clock with the currently driven inputs, then compare.
   task automatic applyStimulus(input string tag);
      modelStep();
      @(posedge clk);
      #1;
      checkOutput(tag);
   endtask

   initial begin
      clearInputs();
      m_pc = 0; m_epc = 0; m_boot = 1; m_handler = 0; m_halted = 0;

      // Reset, then the single BOOT cycle.
      reset = 1;
      applyStimulus("reset0");
      applyStimulus("reset1");
      checkField("boot_pc", 64'(pc), 64'h0);
      checkField("boot_valid", 64'(pc_valid), 64'h0);
      reset = 0;
      applyStimulus("run_first");
      checkField("run_first_pc", 64'(pc), 64'h0);
      checkField("run_first_valid", 64'(pc_valid), 64'h1);
      for (int i = 1; i <= 4; i++) begin
         applyStimulus("seq");
         checkField("seq_pc", 64'(pc), 64'(i * 4));
      end

      // Branch from 0x10 with offset 0x20.
      branch_taken = 1; branch_offset = 32'h20;
      applyStimulus("branch");
      checkField("branch_pc", 64'(pc), 64'h34);
      clearInputs();

      // Region jump from 0x100 to index 0x40.
      jr = 1; jr_addr = 32'h100;
      applyStimulus("jr_to_100");
      clearInputs();
      jump = 1; jump_target = 26'h40;
      applyStimulus("jump");
      checkField("jump_pc", 64'(pc), 64'h100);
      clearInputs();

      // Five nested calls into a four-entry stack.
      for (int i = 0; i < 5; i++) begin
         jump = 1; jump_link = 1; jump_target = 26'h400 + 26'(i * 16);
         applyStimulus("call");
         checkField("call_overflow", 64'(ras_overflow), 64'(i == 4));
      end
      checkField("call_count", 64'(ras_count), 64'h4);
      clearInputs();
      for (int i = 0; i < 5; i++) begin
         jr = 1; ret = 1; jr_addr = 32'h3000;
         applyStimulus("ret");
         checkField("ret_underflow", 64'(ras_underflow), 64'(i == 4));
      end
      checkField("ret_fallback_pc", 64'(pc), 64'h3000);
      clearInputs();

      // Exception entry, return, and double fault.
      jr = 1; jr_addr = 32'h200;
      applyStimulus("jr_to_200");
      clearInputs();
      exc = 1;
      applyStimulus("exc");
      checkField("exc_pc", 64'(pc), 64'h80);
      checkField("exc_epc", 64'(epc), 64'h200);
      clearInputs();
      eret = 1;
      applyStimulus("eret");
      checkField("eret_pc", 64'(pc), 64'h200);
      clearInputs();
      exc = 1;
      applyStimulus("exc2");
      applyStimulus("double_fault");
      checkField("halt_flag", 64'(halted), 64'h1);
      checkField("halt_pc", 64'(pc), 64'h80);
      clearInputs();
      jump = 1; branch_taken = 1; eret = 1;
      for (int i = 0; i < 3; i++) begin
         applyStimulus("halted_hold");
      end
      checkField("halt_pc_frozen", 64'(pc), 64'h80);

      // Reset wins over stall and exc.
      clearInputs();
      reset = 1; stall = 1; exc = 1;
      applyStimulus("reset_over_stall");
      checkField("reset_over_stall_pc", 64'(pc), 64'h0);
      clearInputs();
      applyStimulus("boot_again");

      // Misaligned register jump.
      jr = 1; jr_addr = 32'h102;
      applyStimulus("misaligned");
      checkField("misaligned_pc", 64'(pc), 64'h80);
      checkField("misaligned_flag", 64'(addr_err), 64'h1);
      clearInputs();
      eret = 1;
      applyStimulus("eret_after_misaligned");
      clearInputs();

      // Stall holds the PC for three cycles, exception still taken.
      saved_pc = m_pc;
      stall = 1; jump = 1; jump_link = 1; jump_target = 26'h55;
      for (int i = 0; i < 3; i++) begin
         applyStimulus("stall");
         checkField("stall_pc", 64'(pc), 64'(saved_pc));
      end
      exc = 1;
      applyStimulus("stall_exc");
      checkField("stall_exc_pc", 64'(pc), 64'h80);
      clearInputs();
      eret = 1;
      applyStimulus("eret_back");
      applyStimulus("eret_in_run");

      // Randomized traffic.
      for (int i = 0; i < 400; i++) begin
         clearInputs();
         reset         = m_halted ? ($urandom % 4 == 0) : ($urandom % 100 == 0);
         stall         = ($urandom % 6 == 0);
         exc           = ($urandom % 25 == 0);
         eret          = ($urandom % 10 == 0);
         jr            = ($urandom % 8 == 0);
         ret           = ($urandom % 2 == 0);
         jr_addr       = ($urandom % 6 == 0) ? $urandom : ($urandom & 32'hFFFF_FFFC);
         jump          = ($urandom % 6 == 0);
         jump_link     = ($urandom % 2 == 0);
         jump_target   = 26'($urandom);
         branch_taken  = ($urandom % 5 == 0);
         branch_offset = $urandom & 32'hFFFF_FFFC;
         applyStimulus("random");
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
      $finish;
   end

endmodule
